sap1_top: RTL and testbench

SAP1_TOP -- requirements
Module: sap1_top

---
 rtl/sap1_pkg.sv | 57 +++++
 rtl/sap1_control_unit.sv | 91 +++++++++
 rtl/sap1_top.sv | 70 +++++++
 tb/tb_sap1_top.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 machine: opcodes, control-word bit
// positions, T-state encoding and the default program image.
package sap1_pkg;

  localparam int unsigned T_STATES = 6;

  // Opcodes (upper nibble of the instruction register)
  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit indices (all active-high)
  localparam int unsigned CW_HLT = 11;
  localparam int unsigned CW_CP  = 10;
  localparam int unsigned CW_EP  = 9;
  localparam int unsigned CW_LM  = 8;
  localparam int unsigned CW_CE  = 7;
  localparam int unsigned CW_LI  = 6;
  localparam int unsigned CW_EI  = 5;
  localparam int unsigned CW_LA  = 4;
  localparam int unsigned CW_EA  = 3;
  localparam int unsigned CW_LO  = 2;
  localparam int unsigned CW_EU  = 1;
  localparam int unsigned CW_LB  = 0;

  // Machine cycles T1..T6
  typedef enum logic [2:0] {
    T1 = 3'd0,
    T2 = 3'd1,
    T3 = 3'd2,
    T4 = 3'd3,
    T5 = 3'd4,
    T6 = 3'd5
  } tstate_e;

  // Default 16x8 read-only program image
  function automatic logic [7:0] rom_default(input logic [3:0] addr);
    logic [7:0] data;
    case (addr)
      4'h0:    data = 8'h09;
      4'h1:    data = 8'h1A;
      4'h2:    data = 8'h1B;
      4'h3:    data = 8'h2C;
      4'h4:    data = 8'hE0;
      4'h5:    data = 8'hF0;
      4'h9:    data = 8'h10;
      4'hA:    data = 8'h14;
      4'hB:    data = 8'h18;
      4'hC:    data = 8'h04;
      default: data = 8'h00;
    endcase
    return data;
  endfunction

endpackage

// File: rtl/sap1_control_unit.sv
// SAP-1 control unit: ring counter over T1..T6, halt latch and the
// combinational control-word decoder.
module control_unit
  import sap1_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst,
  input  logic [3:0]  opcode,
  output logic [11:0] control_word
);

  localparam tstate_e T_LAST = tstate_e'(3'(T_STATES - 1));

  tstate_e t_state;
  tstate_e t_next;
  logic    halted;
  logic    halt_next;

  // State register: T-state counter and halt latch
  always_ff @(posedge clk_in) begin
    if (rst) begin
      t_state <= T1;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      halted  <= halt_next;
    end
  end

  // Next-state and control-word decode; a decoded HLT holds the counter at T4
  always_comb begin
    control_word = '0;
    t_next       = t_state;
    halt_next    = halted;
    if (halted) begin
      control_word[CW_HLT] = 1'b1;
    end else begin
      t_next = (t_state == T_LAST) ? T1 : tstate_e'(t_state + 3'd1);
      case (t_state)
        T1: begin
          control_word[CW_EP] = 1'b1;
          control_word[CW_LM] = 1'b1;
        end
        T2: control_word[CW_CP] = 1'b1;
        T3: begin
          control_word[CW_CE] = 1'b1;
          control_word[CW_LI] = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              control_word[CW_EI] = 1'b1;
              control_word[CW_LM] = 1'b1;
            end
            OP_OUT: begin
              control_word[CW_EA] = 1'b1;
              control_word[CW_LO] = 1'b1;
            end
            OP_HLT: begin
              control_word[CW_HLT] = 1'b1;
              halt_next            = 1'b1;
              t_next               = t_state;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              control_word[CW_CE] = 1'b1;
              control_word[CW_LA] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              control_word[CW_CE] = 1'b1;
              control_word[CW_LB] = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            control_word[CW_EU] = 1'b1;
            control_word[CW_LA] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sap1_top.sv
// SAP-1 top level: datapath (PC, MAR, ROM, IR, A, B, ALU, output register)
// around a shared 8-bit bus, sequenced by control_unit.
module sap1_top
  import sap1_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst,
  output logic [7:0] display
);

  logic [3:0]  pc_out;
  logic [3:0]  mar_out;
  logic [7:0]  ir_output;
  logic [3:0]  opcode;
  logic [7:0]  a_out;
  logic [7:0]  b_out;
  logic [7:0]  bus;
  logic [7:0]  ram_data;
  logic [7:0]  alu_result;
  logic [11:0] control_word;
  logic        pc_enable;
  logic        mar_load;

  assign opcode    = ir_output[7:4];
  assign pc_enable = control_word[CW_CP];
  assign mar_load  = control_word[CW_LM];
  assign ram_data  = rom_default(mar_out);

  control_unit u_control_unit (
    .clk_in       (clk_in),
    .rst          (rst),
    .opcode       (opcode),
    .control_word (control_word)
  );

  // ALU: add, or subtract for SUB, modulo 256
  always_comb begin
    alu_result = (opcode == OP_SUB) ? (a_out - b_out) : (a_out + b_out);
  end

  // Bus source select, fixed priority Ep > Ei > CE > Ea > Eu
  always_comb begin
    bus = '0;
    if (control_word[CW_EP])      bus = {4'h0, pc_out};
    else if (control_word[CW_EI]) bus = {4'h0, ir_output[3:0]};
    else if (control_word[CW_CE]) bus = ram_data;
    else if (control_word[CW_EA]) bus = a_out;
    else if (control_word[CW_EU]) bus = alu_result;
  end

  // Datapath registers load from the bus under their control bits
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pc_out    <= '0;
      mar_out   <= '0;
      ir_output <= '0;
      a_out     <= '0;
      b_out     <= '0;
      display   <= '0;
    end else begin
      if (pc_enable)            pc_out    <= pc_out + 4'd1;
      if (mar_load)             mar_out   <= bus[3:0];
      if (control_word[CW_LI])  ir_output <= bus;
      if (control_word[CW_LA])  a_out     <= bus;
      if (control_word[CW_LB])  b_out     <= bus;
      if (control_word[CW_LO])  display   <= bus;
    end
  end

endmodule

// File: tb/tb_sap1_top.sv
// Self-checking bench for sap1_top: instruction-level reference model,
// default program, mid-instruction reset, wrap cases and random images.
module tb_sap1_top;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [7:0] display;

  sap1_top dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .display (display)
  );

  always #5 clk_in = ~clk_in;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [7:0] img [16];
  logic [7:0] ram_val;
  bit         use_force = 1'b0;

  // Reference machine state
  logic [3:0] m_pc;
  logic [7:0] m_a, m_b, m_out;
  logic [7:0] bseq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    if (use_force) ram_val = img[dut.mar_out];
  endtask

  task automatic load_default_img();
    for (int unsigned i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h09; img[1] = 8'h1A; img[2] = 8'h1B;
    img[3] = 8'h2C; img[4] = 8'hE0; img[5] = 8'hF0;
    img[9] = 8'h10; img[10] = 8'h14; img[11] = 8'h18; img[12] = 8'h04;
  endtask

  task automatic model_reset();
    m_pc = 4'h0; m_a = 8'h00; m_b = 8'h00; m_out = 8'h00;
    bseq.delete();
  endtask

  task automatic check_cleared(input string pfx);
    chk({pfx, "_pc"},   dut.pc_out, 0);
    chk({pfx, "_mar"},  dut.mar_out, 0);
    chk({pfx, "_ir"},   dut.ir_output, 0);
    chk({pfx, "_a"},    dut.a_out, 0);
    chk({pfx, "_b"},    dut.b_out, 0);
    chk({pfx, "_disp"}, display, 0);
    chk({pfx, "_t"},    dut.u_control_unit.t_state, 0);
  endtask

  // Two reset cycles, then check the cleared state in the first T1
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_reset();
    check_cleared("rst");
    chk("rst_cw",  dut.control_word, 12'h300);
    chk("rst_bus", dut.bus, 8'h00);
  endtask

  task automatic start_force();
    ram_val   = img[dut.mar_out];
    use_force = 1'b1;
    force dut.ram_data = ram_val;
  endtask

  task automatic stop_force();
    release dut.ram_data;
    use_force = 1'b0;
  endtask

  // Executes up to max_instr instructions from the model's current state,
  // checking the DUT at fetch end, T4 and instruction end; stops on HLT.
  task automatic run_instrs(input int unsigned max_instr, output int unsigned halt_cyc);
    int unsigned cyc;
    cyc      = 0;
    halt_cyc = 0;
    for (int unsigned i = 0; i < max_instr; i++) begin
      logic [7:0] ins;
      logic [3:0] op;
      logic [3:0] arg;
      logic [7:0] exp_bus;
      ins = img[m_pc];
      op  = ins[7:4];
      arg = ins[3:0];
      chk("t1_cw", dut.control_word, 12'h300);
      chk("t1_t",  dut.u_control_unit.t_state, 0);
      tick(); tick(); tick();
      cyc += 3;
      m_pc = m_pc + 4'd1;
      chk("fetch_ir", dut.ir_output, ins);
      chk("fetch_pc", dut.pc_out, m_pc);
      chk("opcode",   dut.opcode, op);
      if (op == 4'hF) begin
        halt_cyc = cyc + 1;
        chk("hlt_cw", dut.control_word, 12'h800);
        for (int unsigned k = 0; k < 20; k++) begin
          tick();
          chk("halt_cw11", dut.control_word[11], 1);
          chk("halt_pc",   dut.pc_out, m_pc);
          chk("halt_a",    dut.a_out, m_a);
          chk("halt_disp", display, m_out);
          chk("halt_t",    dut.u_control_unit.t_state, 3);
        end
        return;
      end
      if (op == 4'h0 || op == 4'h1 || op == 4'h2) exp_bus = {4'h0, arg};
      else if (op == 4'hE)                        exp_bus = m_a;
      else                                        exp_bus = 8'h00;
      chk("t4_bus", dut.bus, exp_bus);
      tick(); tick(); tick();
      cyc += 3;
      case (op)
        4'h0: m_a = img[arg];
        4'h1: begin m_b = img[arg]; m_a = m_a + m_b; bseq.push_back(m_b); end
        4'h2: begin m_b = img[arg]; m_a = m_a - m_b; bseq.push_back(m_b); end
        4'hE: m_out = m_a;
        default: ;
      endcase
      chk("end_a",    dut.a_out, m_a);
      chk("end_b",    dut.b_out, m_b);
      chk("end_disp", display, m_out);
    end
  endtask

  initial begin
    int unsigned hc;
    logic [7:0]  exp_b [3];

    // Default program from the built-in ROM
    load_default_img();
    do_reset();
    run_instrs(10, hc);
    chk("hlt_cycle", hc, 34);
    chk("dflt_disp", display, 8'h38);
    exp_b[0] = 8'h14; exp_b[1] = 8'h18; exp_b[2] = 8'h04;
    chk("bseq_len", bseq.size(), 3);
    for (int unsigned i = 0; i < 3 && i < bseq.size(); i++) chk("bseq", bseq[i], exp_b[i]);

    // Reset during T5 of the ADD at address 1, then full rerun
    do_reset();
    run_instrs(1, hc);
    tick(); tick(); tick(); tick();
    chk("pre_rst_t", dut.u_control_unit.t_state, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("mid");
    model_reset();
    run_instrs(10, hc);
    chk("rerun_disp", display, 8'h38);

    // ADD wrap: A = 0x10 + 0xFF + 0x02
    load_default_img();
    img[10] = 8'hFF;
    img[11] = 8'h02;
    start_force();
    do_reset();
    run_instrs(3, hc);
    chk("add_wrap", dut.a_out, 8'h11);
    run_instrs(10, hc);

    // SUB wrap with B > A: 0x05 - 0x07
    for (int unsigned i = 0; i < 16; i++) img[i] = 8'h00;
    img[0] = 8'h09; img[1] = 8'h2A; img[2] = 8'hE0; img[3] = 8'hF0;
    img[9] = 8'h05; img[10] = 8'h07;
    do_reset();
    run_instrs(2, hc);
    chk("sub_wrap", dut.a_out, 8'hFE);
    run_instrs(10, hc);
    chk("sub_disp", display, 8'hFE);

    // Random program images
    for (int unsigned r = 0; r < 25; r++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        int unsigned sel;
        logic [3:0]  op;
        sel = $urandom_range(0, 9);
        if (sel <= 2)      op = 4'h0;
        else if (sel <= 4) op = 4'h1;
        else if (sel <= 6) op = 4'h2;
        else if (sel == 7) op = 4'hE;
        else if (sel == 8) op = 4'hF;
        else               op = 4'($urandom_range(3, 13));
        img[i] = {op, 4'($urandom_range(0, 15))};
      end
      ram_val = img[dut.mar_out];
      do_reset();
      run_instrs(24, hc);
    end
    stop_force();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
